sdram_frame_sched: RTL and testbench

//  Single-clock (SDRAM clock) scheduler that shares the one req/ack port pair of sdram_top

---
 rtl/sdram_frame_sched.sv | 183 ++++++++++++++++++
 tb/tb_sdram_frame_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : sdram_frame_sched
// Brief   : Arbitrates one-row SDRAM bursts between the camera writer and the
//           VGA reader. It generates row addresses and tracks frame boundaries.
//           Optional SDRAM_SCHED_PINGPONG_EN adds double-buffered frames.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_frame_sched #(
    parameter int ADDR_W     = 24,
    parameter int FIFO_W     = 11,
    parameter int ROW_LSB    = 9,
    parameter int FRAME_ROWS = 128,
    parameter int WR_THRESH  = 512,
    parameter int RD_THRESH  = 512,
    parameter int WR_MAX_RUN = 4,
    parameter int BUF_BIT    = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FIFO_W-1:0] cam_fifo_used,
    input  logic [FIFO_W-1:0] vga_fifo_used,
    input  logic              cam_frame_start,
    input  logic              vga_frame_start,
    output logic              wr_sdram_req,
    input  logic              wr_sdram_ack,
    output logic [ADDR_W-1:0] wr_sdram_add,
    output logic              rd_sdram_req,
    input  logic              rd_sdram_ack,
    output logic [ADDR_W-1:0] rd_sdram_add,
    output logic              frame_ready,
    output logic              wr_ovf
);

    localparam int                 c_row_w      = 13;
    localparam int                 c_run_w      = $clog2(WR_MAX_RUN + 1);
    localparam logic [c_row_w-1:0] c_frame_rows = c_row_w'(FRAME_ROWS);
    localparam logic [FIFO_W-1:0]  c_wr_thresh  = FIFO_W'(WR_THRESH);
    localparam logic [FIFO_W-1:0]  c_rd_thresh  = FIFO_W'(RD_THRESH);
    localparam logic [c_run_w-1:0] c_max_run    = c_run_w'(WR_MAX_RUN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_row_w-1:0] r_wr_row, r_rd_row;
    logic [c_row_w-1:0] w_wr_row_eff, w_rd_row_eff, w_wr_row_inc;
    logic [c_run_w-1:0] r_run;
    logic [ADDR_W-1:0]  r_wr_add, r_rd_add;
    logic               r_wr_pend, r_rd_pend, r_frame_ready, r_wr_ovf;
    logic               w_wr_restart, w_rd_restart, w_wr_el, w_rd_el;
    logic               w_wr_grant, w_rd_grant, w_wr_done, w_rd_done, w_wr_wrap;
    logic               w_wr_buf, w_rd_buf_eff;

    function automatic logic [ADDR_W-1:0] f_add(input logic [c_row_w-1:0] row,
                                                 input logic bsel);
        logic [ADDR_W-1:0] a;
        a                   = '0;
        a[ROW_LSB+:c_row_w] = row;
        a[BUF_BIT]          = bsel;
        return a;
    endfunction

    // A frame start seen outside its own burst takes effect immediately, so a
    // grant on the same edge already targets row 0.
    assign w_wr_restart = cam_frame_start && (r_state != S_WR);
    assign w_rd_restart = vga_frame_start && (r_state != S_RD);
    assign w_wr_row_eff = w_wr_restart ? '0 : r_wr_row;
    assign w_rd_row_eff = w_rd_restart ? '0 : r_rd_row;
    assign w_wr_row_inc = r_wr_row + 13'd1;

    assign w_wr_el   = (cam_fifo_used >= c_wr_thresh) && (w_wr_row_eff < c_frame_rows);
    assign w_rd_el   = r_frame_ready && (vga_fifo_used <= c_rd_thresh) &&
                       (w_rd_row_eff < c_frame_rows);
    assign w_wr_done = (r_state == S_WR) && wr_sdram_ack;
    assign w_rd_done = (r_state == S_RD) && rd_sdram_ack;
    assign w_wr_wrap = w_wr_done && !(r_wr_pend || cam_frame_start) &&
                       (w_wr_row_inc == c_frame_rows);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_grant  = 1'b0;
        w_rd_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_el && !(w_rd_el && (r_run == c_max_run))) begin
                    w_wr_grant  = 1'b1;
                    w_state_nxt = S_WR;
                end else if (w_rd_el) begin
                    w_rd_grant  = 1'b1;
                    w_state_nxt = S_RD;
                end
            end
            S_WR:    if (wr_sdram_ack) w_state_nxt = S_GAP;
            S_RD:    if (rd_sdram_ack) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_row      <= '0;
            r_rd_row      <= '0;
            r_wr_pend     <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_run         <= '0;
            r_wr_add      <= '0;
            r_rd_add      <= '0;
            r_frame_ready <= 1'b0;
            r_wr_ovf      <= 1'b0;
        end else begin
            if (w_wr_done) begin
                r_wr_row  <= (r_wr_pend || cam_frame_start) ? '0 : w_wr_row_inc;
                r_wr_pend <= 1'b0;
            end else if (cam_frame_start) begin
                if (r_state == S_WR) r_wr_pend <= 1'b1;
                else                 r_wr_row  <= '0;
            end

            if (w_rd_done) begin
                r_rd_row  <= (r_rd_pend || vga_frame_start) ? '0 : r_rd_row + 13'd1;
                r_rd_pend <= 1'b0;
            end else if (vga_frame_start) begin
                if (r_state == S_RD) r_rd_pend <= 1'b1;
                else                 r_rd_row  <= '0;
            end

            // Write streak only matters while a read is waiting for its turn.
            if (r_state == S_IDLE) begin
                if (!w_rd_el || w_rd_grant) r_run <= '0;
                else if (w_wr_grant)        r_run <= r_run + c_run_w'(1);
            end

            if (w_wr_grant) r_wr_add <= f_add(w_wr_row_eff, w_wr_buf);
            if (w_rd_grant) r_rd_add <= f_add(w_rd_row_eff, w_rd_buf_eff);
            if (w_wr_wrap)  r_frame_ready <= 1'b1;
            if (cam_fifo_used == {FIFO_W{1'b1}}) r_wr_ovf <= 1'b1;
        end
    end

`ifdef SDRAM_SCHED_PINGPONG_EN
    logic r_wr_buf, r_rd_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_buf <= 1'b0;
            r_rd_buf <= 1'b0;
        end else begin
            if (w_wr_wrap) r_wr_buf <= ~r_wr_buf;
            if (w_rd_done) begin
                if (r_rd_pend || vga_frame_start) r_rd_buf <= ~r_wr_buf;
            end else if (w_rd_restart) begin
                r_rd_buf <= ~r_wr_buf;
            end
        end
    end

    assign w_wr_buf     = r_wr_buf;
    assign w_rd_buf_eff = w_rd_restart ? ~r_wr_buf : r_rd_buf;
`else
    assign w_wr_buf     = 1'b0;
    assign w_rd_buf_eff = 1'b0;
`endif

    assign wr_sdram_req = (r_state == S_WR);
    assign rd_sdram_req = (r_state == S_RD);
    assign wr_sdram_add = r_wr_add;
    assign rd_sdram_add = r_rd_add;
    assign frame_ready  = r_frame_ready;
    assign wr_ovf       = r_wr_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sdram_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_frame_sched
// Brief   : Randomized self-checking bench for sdram_frame_sched against a
//           cycle-level behavioural model of the scheduling rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdram_frame_sched;

    localparam int FRAME_ROWS = 128;
    localparam int WR_THRESH  = 512;
    localparam int RD_THRESH  = 512;
    localparam int WR_MAX_RUN = 4;
`ifdef SDRAM_SCHED_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif
    localparam int PH_IDLE = 0, PH_WR = 1, PH_RD = 2, PH_GAP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cam_fifo_used, vga_fifo_used;
    logic        cam_frame_start, vga_frame_start;
    logic        wr_sdram_req, wr_sdram_ack, rd_sdram_req, rd_sdram_ack;
    logic [23:0] wr_sdram_add, rd_sdram_add;
    logic        frame_ready, wr_ovf;

    sdram_frame_sched dut (
        .clk             (clk),
        .rst             (rst),
        .cam_fifo_used   (cam_fifo_used),
        .vga_fifo_used   (vga_fifo_used),
        .cam_frame_start (cam_frame_start),
        .vga_frame_start (vga_frame_start),
        .wr_sdram_req    (wr_sdram_req),
        .wr_sdram_ack    (wr_sdram_ack),
        .wr_sdram_add    (wr_sdram_add),
        .rd_sdram_req    (rd_sdram_req),
        .rd_sdram_ack    (rd_sdram_ack),
        .rd_sdram_add    (rd_sdram_add),
        .frame_ready     (frame_ready),
        .wr_ovf          (wr_ovf)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    int          m_ph, m_wr_row, m_rd_row, m_run;
    bit          m_wr_pend, m_rd_pend, m_ready, m_ovf, m_wr_buf, m_rd_buf;
    logic [23:0] m_wr_add, m_rd_add;

    function automatic logic [23:0] mk_add(input int row, input bit b);
        return 24'(row * 512 + (b ? 4194304 : 0));
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_wr_row = 0; m_rd_row = 0; m_run = 0;
        m_wr_pend = 0; m_rd_pend = 0; m_ready = 0; m_ovf = 0;
        m_wr_buf = 0; m_rd_buf = 0; m_wr_add = '0; m_rd_add = '0;
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        int wrow, rrow;
        bit rb, wel, rel, wg, rg, old_wbuf;
        if (rst) begin
            model_reset();
            return;
        end
        old_wbuf = m_wr_buf;
        wrow = (cam_frame_start && m_ph != PH_WR) ? 0 : m_wr_row;
        rrow = (vga_frame_start && m_ph != PH_RD) ? 0 : m_rd_row;
        rb   = PP ? ((vga_frame_start && m_ph != PH_RD) ? !old_wbuf : m_rd_buf) : 1'b0;
        wg = 0; rg = 0;
        if (m_ph == PH_IDLE) begin
            wel = (int'(cam_fifo_used) >= WR_THRESH) && (wrow < FRAME_ROWS);
            rel = m_ready && (int'(vga_fifo_used) <= RD_THRESH) && (rrow < FRAME_ROWS);
            if (wel && !(rel && m_run == WR_MAX_RUN)) wg = 1;
            else if (rel)                            rg = 1;
            if (!rel || rg) m_run = 0;
            else if (wg)    m_run = m_run + 1;
        end
        if (cam_fifo_used == 11'h7ff) m_ovf = 1;

        if (m_ph == PH_WR && wr_sdram_ack) begin
            if (m_wr_pend || cam_frame_start) m_wr_row = 0;
            else begin
                m_wr_row = m_wr_row + 1;
                if (m_wr_row == FRAME_ROWS) begin
                    m_ready = 1;
                    if (PP) m_wr_buf = !m_wr_buf;
                end
            end
            m_wr_pend = 0;
        end else if (cam_frame_start && m_ph == PH_WR) m_wr_pend = 1;
        else m_wr_row = wrow;

        if (m_ph == PH_RD && rd_sdram_ack) begin
            if (m_rd_pend || vga_frame_start) begin
                m_rd_row = 0;
                if (PP) m_rd_buf = !old_wbuf;
            end else m_rd_row = m_rd_row + 1;
            m_rd_pend = 0;
        end else if (vga_frame_start && m_ph == PH_RD) m_rd_pend = 1;
        else begin
            m_rd_row = rrow;
            m_rd_buf = rb;
        end

        if (wg) m_wr_add = mk_add(wrow, old_wbuf);
        if (rg) m_rd_add = mk_add(rrow, rb);

        case (m_ph)
            PH_IDLE: m_ph = wg ? PH_WR : (rg ? PH_RD : PH_IDLE);
            PH_WR:   if (wr_sdram_ack) m_ph = PH_GAP;
            PH_RD:   if (rd_sdram_ack) m_ph = PH_GAP;
            default: m_ph = PH_IDLE;
        endcase
    endtask

    int  fixed_lat = -1, lat_cnt = 0, n_wr_grants = 0;
    bit  rand_acks = 0, hold_ack = 0, rec = 0, prev_wr = 0, prev_rd = 0;
    byte grant_q[$];

    task automatic cycle();
        model_edge();
        @(negedge clk);
        check_eq("wr_req", {31'd0, wr_sdram_req}, {31'd0, m_ph == PH_WR});
        check_eq("rd_req", {31'd0, rd_sdram_req}, {31'd0, m_ph == PH_RD});
        check_eq("wr_add", {8'd0, wr_sdram_add}, {8'd0, m_wr_add});
        check_eq("rd_add", {8'd0, rd_sdram_add}, {8'd0, m_rd_add});
        check_eq("frame_ready", {31'd0, frame_ready}, {31'd0, m_ready});
        check_eq("wr_ovf", {31'd0, wr_ovf}, {31'd0, m_ovf});
        if (wr_sdram_req && !prev_wr) begin
            n_wr_grants++;
            if (rec) grant_q.push_back("W");
        end
        if (rd_sdram_req && !prev_rd && rec) grant_q.push_back("R");
        prev_wr = wr_sdram_req;
        prev_rd = rd_sdram_req;
        cam_frame_start = 0;
        vga_frame_start = 0;
        wr_sdram_ack = 0;
        rd_sdram_ack = 0;
        if (!hold_ack) begin
            if (m_ph == PH_WR || m_ph == PH_RD) begin
                if (lat_cnt <= 0) begin
                    if (m_ph == PH_WR) wr_sdram_ack = 1;
                    else               rd_sdram_ack = 1;
                end else lat_cnt--;
            end else lat_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            if (rand_acks) begin
                if (m_ph != PH_WR && $urandom_range(0, 39) == 0) wr_sdram_ack = 1;
                if (m_ph != PH_RD && $urandom_range(0, 39) == 0) rd_sdram_ack = 1;
            end
        end
    endtask

    initial begin
        string exp_order;
        bit    found;
        rst = 1; cam_fifo_used = '0; vga_fifo_used = 11'h7ff;
        cam_frame_start = 0; vga_frame_start = 0; wr_sdram_ack = 0; rd_sdram_ack = 0;
        model_reset();
        fixed_lat = 7;
        repeat (3) cycle();
        check_eq("reset_wr_add", {8'd0, wr_sdram_add}, 32'd0);
        check_eq("reset_ready", {31'd0, frame_ready}, 32'd0);
        rst = 0;

        // One full frame of writes with fixed ack latency
        cam_fifo_used = 11'd600;
        n_wr_grants = 0;
        for (int i = 0; i < 128 * 12 + 40; i++) cycle();
        check_eq("t2_write_count", n_wr_grants, 32'd128);
        check_eq("t2_frame_ready", {31'd0, frame_ready}, 32'd1);

        // Write streak limit while reads are eligible
        fixed_lat = -1;
        cam_fifo_used = '0; vga_fifo_used = 11'h7ff;
        repeat (20) cycle();
        cam_fifo_used = 11'd600; vga_fifo_used = 11'd100;
        cam_frame_start = 1; vga_frame_start = 1;
        grant_q.delete();
        rec = 1;
        for (int i = 0; i < 200 && grant_q.size() < 10; i++) cycle();
        rec = 0;
        check_eq("t3_grant_count", grant_q.size(), 32'd10);
        exp_order = "WWWWRWWWWR";
        for (int k = 0; k < 10 && k < grant_q.size(); k++)
            check_eq($sformatf("t3_order_%0d", k), {24'd0, grant_q[k]}, {24'd0, exp_order[k]});

        // Overflow flag is sticky
        check_eq("t5_ovf_pre", {31'd0, wr_ovf}, 32'd0);
        cam_fifo_used = 11'h7ff;
        cycle();
        cam_fifo_used = 11'd600;
        check_eq("t5_ovf_set", {31'd0, wr_ovf}, 32'd1);
        repeat (30) cycle();
        check_eq("t5_ovf_hold", {31'd0, wr_ovf}, 32'd1);

        // Randomized traffic, frame starts (incl. mid-burst) and stray acks
        rand_acks = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 9) == 0)
                cam_fifo_used = 11'(511 + $urandom_range(0, 1));
            else if ($urandom_range(0, 7) == 0)
                cam_fifo_used = 11'($urandom_range(0, 511));
            else
                cam_fifo_used = 11'($urandom_range(512, 2047));
            if ($urandom_range(0, 9) == 0)
                vga_fifo_used = 11'(512 + $urandom_range(0, 1));
            else if ($urandom_range(0, 1) == 0)
                vga_fifo_used = 11'($urandom_range(0, 512));
            else
                vga_fifo_used = 11'($urandom_range(513, 2047));
            cam_frame_start = ($urandom_range(0, 199) == 0) ||
                              (m_wr_row >= FRAME_ROWS && $urandom_range(0, 19) == 0) ||
                              (m_ph == PH_WR && $urandom_range(0, 49) == 0);
            vga_frame_start = ($urandom_range(0, 149) == 0) ||
                              (m_rd_row >= FRAME_ROWS && $urandom_range(0, 19) == 0) ||
                              (m_ph == PH_RD && $urandom_range(0, 24) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of a write burst
        rand_acks = 0; hold_ack = 1;
        wr_sdram_ack = 0; rd_sdram_ack = 0;
        cam_fifo_used = 11'd600; vga_fifo_used = 11'h7ff;
        cam_frame_start = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = wr_sdram_req;
        end
        check_eq("t1_req_seen", {31'd0, found}, 32'd1);
        #1 rst = 1;
        #1;
        check_eq("t1_async_wr_req", {31'd0, wr_sdram_req}, 32'd0);
        check_eq("t1_async_rd_req", {31'd0, rd_sdram_req}, 32'd0);
        check_eq("t1_async_add", {8'd0, wr_sdram_add}, 32'd0);
        check_eq("t1_async_ready", {31'd0, frame_ready}, 32'd0);
        check_eq("t1_async_ovf", {31'd0, wr_ovf}, 32'd0);
        model_reset();
        cam_fifo_used = '0;
        repeat (2) cycle();
        rst = 0;
        hold_ack = 0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
